// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_t          : run/pause/lap FSM encoding (3 bits)
//   DEBOUNCE_DEFAULT : default stable-cycle count for the button debouncers
//   CNT_W_DEFAULT    : default debounce counter width (2**CNT_W > DEBOUNCE)
//   is_running       : state advances the centisecond counter
//   is_frozen        : state shows the lap latch instead of the live count
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_LAP_RUN   = 3'd3,
    ST_LAP_PAUSE = 3'd4
  } state_t;

  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int CNT_W_DEFAULT    = 5;

  function automatic logic is_running(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP_RUN);
  endfunction

  function automatic logic is_frozen(input state_t s);
    return (s == ST_LAP_RUN) || (s == ST_LAP_PAUSE);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button input path: 2-FF synchroniser, stable-count debouncer
// and a registered one-cycle press pulse on the debounced rising edge.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   button      in  raw asynchronous button, active-high
//   press_pulse out high for exactly one cycle per accepted press
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [1:0]       sync_valid;
  logic             armed;
  logic [CNT_W-1:0] stable_cnt;
  logic             level;
  logic             level_d;

  // The synchroniser output only becomes a real sample two cycles after
  // reset (sync_valid tracks that). Presses are armed only once the button
  // has been seen released, so a button held through reset cannot produce
  // a press until it is let go and pressed again.
  // The stable counter runs while the synchronised input disagrees with
  // the accepted level and clears the moment they agree, so any glitch
  // shorter than DEBOUNCE_CYCLES leaves the accepted level untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      sync_q      <= 1'b0;
      sync_valid  <= 2'b00;
      armed       <= 1'b0;
      stable_cnt  <= '0;
      level       <= 1'b0;
      level_d     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_meta  <= button;
      sync_q     <= sync_meta;
      sync_valid <= {sync_valid[0], 1'b1};
      if (sync_valid[1] && !sync_q) begin
        armed <= 1'b1;
      end
      if (sync_q == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= ~level;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      level_d     <= level;
      press_pulse <= level & ~level_d & armed;
    end
  end

endmodule

// File: rtl/stopwatch_button_controller.sv
// Stopwatch sequencing: debounces the start/stop, lap and reset buttons
// and runs the IDLE/RUN/PAUSE/LAP_RUN/LAP_PAUSE FSM that controls the
// centisecond counter, lap latch and display.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ena                   block enable; low drops events and holds the FSM
//   i_button_start_stop   raw button, active-high
//   i_button_lap_time     raw button, active-high
//   i_button_reset        raw button, active-high
//   o_count_en            counter advances while high
//   o_count_clear         one-cycle pulse: clear counter and lap latch
//   o_lap_capture         one-cycle pulse: lap latch loads current count
//   o_display_freeze      display shows lap latch instead of live count
//   o_stopwatch_enabled   status LED, mirrors o_count_en
//   o_display_enabled     status LED, high whenever not IDLE
module stopwatch_button_controller
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic i_button_start_stop,
  input  logic i_button_lap_time,
  input  logic i_button_reset,
  output logic o_count_en,
  output logic o_count_clear,
  output logic o_lap_capture,
  output logic o_display_freeze,
  output logic o_stopwatch_enabled,
  output logic o_display_enabled
);

  logic   ev_start_stop;
  logic   ev_lap;
  logic   ev_reset;
  logic   take_reset;
  logic   take_start_stop;
  logic   take_lap;
  state_t state;
  state_t state_next;
  logic   clear_next;
  logic   capture_next;
  logic   clear_q;
  logic   capture_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start_stop (
    .clk(clk), .rst(rst), .button(i_button_start_stop), .press_pulse(ev_start_stop)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_lap (
    .clk(clk), .rst(rst), .button(i_button_lap_time), .press_pulse(ev_lap)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
    .clk(clk), .rst(rst), .button(i_button_reset), .press_pulse(ev_reset)
  );

  // Only the highest-priority event of a cycle is considered; it consumes
  // the cycle even when the current state ignores it.
  assign take_reset      = ena & ev_reset;
  assign take_start_stop = ena & ev_start_stop & ~ev_reset;
  assign take_lap        = ena & ev_lap & ~ev_reset & ~ev_start_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      clear_q   <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      state     <= state_next;
      clear_q   <= clear_next;
      capture_q <= capture_next;
    end
  end

  // Next state plus the clear/capture pulses, which are registered
  // alongside the state so they line up with the transition.
  always_comb begin
    state_next   = state;
    clear_next   = 1'b0;
    capture_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_start_stop) state_next = ST_RUN;
        else if (take_reset) clear_next = 1'b1;
      end
      ST_RUN: begin
        if (take_start_stop) state_next = ST_PAUSE;
        else if (take_lap) begin
          state_next   = ST_LAP_RUN;
          capture_next = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (take_start_stop) state_next = ST_RUN;
        else if (take_reset) begin
          state_next = ST_IDLE;
          clear_next = 1'b1;
        end
      end
      ST_LAP_RUN: begin
        if (take_start_stop) state_next = ST_LAP_PAUSE;
        else if (take_lap) state_next = ST_RUN;
      end
      ST_LAP_PAUSE: begin
        if (take_start_stop) state_next = ST_LAP_RUN;
        else if (take_lap) state_next = ST_PAUSE;
        else if (take_reset) begin
          state_next = ST_IDLE;
          clear_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_count_en          = is_running(state);
  assign o_stopwatch_enabled = is_running(state);
  assign o_display_freeze    = is_frozen(state);
  assign o_display_enabled   = (state != ST_IDLE);
  assign o_count_clear       = clear_q;
  assign o_lap_capture       = capture_q;

endmodule
